// File: rtl/sub_adder_16.sv
// sub_adder_16: registered 16-bit carry-lookahead adder/subtractor with carry/borrow and status flags
module sub_adder_16 #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic             sub,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH:0]   Diff,
  output logic             out_valid,
  output logic             zero,
  output logic             neg,
  output logic             ovf
);
  logic [WIDTH-1:0] bx, g, p, c, s;
  logic [3:0] gg, gp, t;
  logic [4:0] gc;
  logic cout, v;
  // Returns carries c1..c4 of a 4-bit lookahead block; with ci=0, bit 3 is the group generate.
  function automatic logic [3:0] lac4(input logic [3:0] g4, input logic [3:0] p4, input logic ci);
    lac4[0] = g4[0] | (p4[0] & ci);
    lac4[1] = g4[1] | (p4[1] & g4[0]) | (p4[1] & p4[0] & ci);
    lac4[2] = g4[2] | (p4[2] & g4[1]) | (p4[2] & p4[1] & g4[0]) | (p4[2] & p4[1] & p4[0] & ci);
    lac4[3] = g4[3] | (p4[3] & g4[2]) | (p4[3] & p4[2] & g4[1]) | (p4[3] & p4[2] & p4[1] & g4[0])
            | (p4[3] & p4[2] & p4[1] & p4[0] & ci);
  endfunction
  always_comb begin
    t = '0;
    gg = '0;
    gp = '0;
    c = '0;
    bx = B ^ {WIDTH{sub}};
    g = A & bx;
    p = A ^ bx;
    for (int k = 0; k < 4; k++) begin
      t = lac4(g[4*k +: 4], p[4*k +: 4], 1'b0);
      gg[k] = t[3];
      gp[k] = &p[4*k +: 4];
    end
    gc = {lac4(gg, gp, sub), sub};
    for (int k = 0; k < 4; k++) begin
      t = lac4(g[4*k +: 4], p[4*k +: 4], gc[k]);
      c[4*k +: 4] = {t[2:0], gc[k]};
    end
    s = p ^ c;
    cout = gc[4];
    v = c[WIDTH-1] ^ cout;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      Diff <= '0;
      out_valid <= 1'b0;
      zero <= 1'b0;
      neg <= 1'b0;
      ovf <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Diff <= {cout ^ sub, s};
        zero <= ~|s;
        neg <= s[WIDTH-1];
        ovf <= v;
      end
    end
  end
endmodule

// File: tb/tb_sub_adder_16.sv
// tb_sub_adder_16: scoreboard bench; driver queues expected results, monitor checks each output
module tb_sub_adder_16;
  logic clk = 0, rst_n = 0, in_valid = 0, sub = 0;
  logic [15:0] A = 0, B = 0;
  logic [16:0] Diff;
  logic out_valid, zero, neg, ovf;
  logic [19:0] q[$];
  logic [19:0] last_exp = '0;
  int checks = 0, passed = 0;
  logic [15:0] pa[25] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h8000, 16'h7FFF, 16'h8000, 16'h7FFF, 16'h5555,
                          16'hAAAA, 16'h1234, 16'hFFFF, 16'h0000, 16'h8001, 16'h00FF, 16'hFF00, 16'h0F0F,
                          16'hF0F0, 16'h4000, 16'hC000, 16'h7FFE, 16'h0010, 16'hBEEF, 16'hDEAD, 16'h0001, 16'h8000};
  logic [15:0] pb[25] = '{16'h0000, 16'h0001, 16'h0001, 16'h8000, 16'h0001, 16'h0001, 16'h7FFF, 16'hAAAA,
                          16'h5555, 16'h4321, 16'hFFFF, 16'hFFFF, 16'h7FFF, 16'h0001, 16'h0100, 16'hF0F0,
                          16'h0F0F, 16'h4000, 16'hC000, 16'h0002, 16'h0F00, 16'hCAFE, 16'hBEEF, 16'h8000, 16'h7FFF};

  sub_adder_16 dut (.clk(clk), .rst_n(rst_n), .in_valid(in_valid), .sub(sub), .A(A), .B(B),
                    .Diff(Diff), .out_valid(out_valid), .zero(zero), .neg(neg), .ovf(ovf));

  always #5 clk = ~clk;

  function automatic logic [19:0] model(input logic [15:0] a, input logic [15:0] b, input logic s);
    logic [16:0] d;
    logic o;
    d = s ? ({1'b0, a} - {1'b0, b}) : ({1'b0, a} + {1'b0, b});
    o = s ? (a[15] != b[15] && d[15] != a[15]) : (a[15] == b[15] && d[15] != a[15]);
    return {d, d[15:0] == 16'd0, d[15], o};
  endfunction

  task automatic issue(input logic [15:0] a, input logic [15:0] b, input logic s, input logic [19:0] e);
    @(negedge clk);
    A = a; B = b; sub = s; in_valid = 1;
    q.push_back(e);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      in_valid = 0;
      A = 16'($urandom); B = 16'($urandom); sub = 1'($urandom);
    end
  endtask

  task automatic cmp(input string name, input logic [19:0] act, input logic [19:0] e);
    checks++;
    if (act === e) passed++;
    else $display("FAIL %s: got Diff=%0d z=%0b n=%0b v=%0b, want Diff=%0d z=%0b n=%0b v=%0b",
                  name, act[19:3], act[2], act[1], act[0], e[19:3], e[2], e[1], e[0]);
  endtask

  always @(negedge clk) begin
    if (!rst_n) cmp("reset", {Diff, zero, neg, ovf}, 20'd0);
    else if (out_valid) begin
      if (q.size() == 0) begin
        checks++;
        $display("FAIL spurious_valid: got out_valid=1, want 0 (no request pending)");
      end else begin
        last_exp = q.pop_front();
        cmp("result", {Diff, zero, neg, ovf}, last_exp);
      end
    end else cmp("hold", {Diff, zero, neg, ovf}, last_exp);
  end

  initial begin
    logic [15:0] a, b;
    repeat (2) @(negedge clk);
    rst_n = 1;
    issue(16'd1174, 16'd40968, 0, {17'd42142, 3'b010});
    issue(16'd48898, 16'd60673, 0, {17'd109571, 3'b010});
    issue(16'd24105, 16'd18805, 0, {17'd42910, 3'b011});
    issue(16'd24105, 16'd18805, 1, {17'd5300, 3'b000});
    issue(16'd1174, 16'd40968, 1, {17'd91278, 3'b000});
    issue(16'd24750, 16'd40864, 1, {17'd114958, 3'b011});
    issue(16'd38493, 16'd38493, 1, {17'd0, 3'b100});
    idle(3);
    for (int m = 0; m < 2; m++)
      for (int i = 0; i < 25; i++) issue(pa[i], pb[i], 1'(m), model(pa[i], pb[i], 1'(m)));
    idle(3);
    issue(16'd1, 16'd2, 0, model(16'd1, 16'd2, 0));
    issue(16'd7, 16'd9, 1, model(16'd7, 16'd9, 1));
    @(posedge clk);
    #2 rst_n = 0;
    q.delete();
    last_exp = '0;
    #1 cmp("async_reset", {Diff, out_valid, zero, neg, ovf} == 21'd0 ? 20'd0 : 20'hFFFFF, 20'd0);
    @(negedge clk);
    in_valid = 0;
    rst_n = 1;
    issue(16'd1174, 16'd40968, 1, {17'd91278, 3'b000});
    idle(2);
    for (int i = 0; i < 10000; i++) begin
      a = 16'($urandom); b = 16'($urandom);
      issue(a, b, i[0], model(a, b, i[0]));
      if (i % 997 == 0) idle(1);
    end
    idle(4);
    checks++;
    if (q.size() == 0) passed++;
    else $display("FAIL drain: got %0d pending results, want 0", q.size());
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule
